mux_chan_reg: RTL and testbench



---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_rr_arb.sv | 30 +++
 rtl/mux_chan_reg.sv | 106 ++++++++++
 tb/tb_mux_chan_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-channel multiplexer.
package mux_pkg;

   localparam logic MUX_MODE_FIXED = 1'b0;
   localparam logic MUX_MODE_RR    = 1'b1;

   localparam int MUX_CH_MIN = 2;
   localparam int MUX_CH_MAX = 16;

   // Channel index k steps after base, wrapping at n.
   function automatic int wrap_idx(input int base, input int k, input int n);
      return (base + k) % n;
   endfunction

endpackage

// File: rtl/mux_rr_arb.sv
// Round-robin arbiter: first requester strictly after rr_ptr, wrapping to 0.
module mux_rr_arb
   import mux_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req_i,
   input  logic [SEL_W-1:0]    rr_ptr_i,
   output logic [CHANNELS-1:0] gnt_o,
   output logic [SEL_W-1:0]    idx_o,
   output logic                any_o
);

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 1; k <= CHANNELS; k++) begin
         int c;
         c = wrap_idx(int'(rr_ptr_i), k, CHANNELS);
         if (!any_o && req_i[c]) begin
            any_o    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = SEL_W'(c);
         end
      end
   end

endmodule

// File: rtl/mux_chan_reg.sv
// Registered N-channel valid/ready multiplexer, fixed-select or round-robin.
// Optional MUX_CHAN_REG_TRISTATE_EN floats m_out whenever out_valid is low.
module mux_chan_reg
   import mux_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          select,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          m_out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_ch
);

   localparam int NSEL = 1 << SEL_W;

   if (CHANNELS < MUX_CH_MIN || CHANNELS > MUX_CH_MAX) begin : g_bad_ch
      $error("mux_chan_reg: CHANNELS out of range");
   end

   logic [WIDTH-1:0]    m_q, m_d;
   logic [SEL_W-1:0]    out_ch_q, out_ch_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic                out_valid_q, out_valid_d;

   logic                load;
   logic [NSEL-1:0]     req_ext;
   logic                fx_hit;
   logic [CHANNELS-1:0] fx_gnt, rr_gnt;
   logic [SEL_W-1:0]    rr_idx, gnt_idx;
   logic                rr_any, gnt_vld;
   logic [WIDTH-1:0]    gnt_data;

   assign load = !out_valid_q || out_ready;

   // Zero-padding the request vector makes out-of-range selects never hit.
   assign req_ext = NSEL'(in_valid);
   assign fx_hit  = req_ext[select];
   assign fx_gnt  = fx_hit ? (CHANNELS'(1) << select) : '0;

   mux_rr_arb #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
      .req_i    (in_valid),
      .rr_ptr_i (rr_ptr_q),
      .gnt_o    (rr_gnt),
      .idx_o    (rr_idx),
      .any_o    (rr_any)
   );

   assign gnt_vld  = (mode == MUX_MODE_RR) ? rr_any : fx_hit;
   assign gnt_idx  = (mode == MUX_MODE_RR) ? rr_idx : select;
   assign in_ready = (rst_n && load) ? ((mode == MUX_MODE_RR) ? rr_gnt : fx_gnt) : '0;

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
   end

   always_comb begin
      m_d         = m_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      if (load) begin
         if (gnt_vld) begin
            m_d         = gnt_data;
            out_ch_d    = gnt_idx;
            rr_ptr_d    = gnt_idx;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_q         <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= SEL_W'(CHANNELS - 1);
         out_valid_q <= 1'b0;
      end else begin
         m_q         <= m_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
`ifdef MUX_CHAN_REG_TRISTATE_EN
   assign m_out = out_valid_q ? m_q : 'z;
`else
   assign m_out = m_q;
`endif

endmodule

// File: tb/tb_mux_chan_reg.sv
// Self-checking bench for mux_chan_reg: directed table, corner sequences, random vs model.
module tb_mux_chan_reg;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n, mode, out_ready;
   logic [SW-1:0] select;
   logic [C*W-1:0] in_data;
   logic [C-1:0]  in_valid, in_ready;
   logic [W-1:0]  m_out;
   logic          out_valid;
   logic [SW-1:0] out_ch;

   // Three-channel instance for the out-of-range select case.
   logic [2:0]    in_ready3;
   logic [W-1:0]  m_out3;
   logic          out_valid3;
   logic [1:0]    out_ch3;

   always #5 clk = ~clk;

   mux_chan_reg #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .select(select),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .m_out(m_out), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
   );

   mux_chan_reg #(.WIDTH(W), .CHANNELS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .select(select),
      .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready3),
      .m_out(m_out3), .out_valid(out_valid3), .out_ready(out_ready), .out_ch(out_ch3)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: what the output register should hold.
   bit         known = 0;
   int         m_vld = 0, m_ch = 0, ptr = C - 1;
   logic [W-1:0] m_dat = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant();
      if (mode == 1'b0)
         return (int'(select) < C && in_valid[select]) ? int'(select) : -1;
      for (int k = 1; k <= C; k++)
         if (in_valid[(ptr + k) % C]) return (ptr + k) % C;
      return -1;
   endfunction

   function automatic logic [W-1:0] exp_mout();
`ifdef MUX_CHAN_REG_TRISTATE_EN
      return m_vld ? m_dat : 'z;
`else
      return m_dat;
`endif
   endfunction

   // Inputs are already driven; check, clock once, update model, return at negedge.
   task automatic cyc();
      int g;
      logic [C-1:0] er;
      #1;
      g  = model_grant();
      er = (rst_n && (!m_vld || out_ready) && g >= 0) ? C'(1 << g) : '0;
      chk("in_ready", in_ready, er);
      if (known) begin
         chk("out_valid", out_valid, m_vld[0]);
         chk("out_ch", out_ch, m_ch[SW-1:0]);
         chk("m_out", m_out, exp_mout());
      end
      @(posedge clk);
      if (!rst_n) begin
         m_vld = 0; m_dat = '0; m_ch = 0; ptr = C - 1; known = 1;
      end else if (!m_vld || out_ready) begin
         if (g >= 0) begin
            m_dat = in_data[g*W +: W]; m_ch = g; m_vld = 1; ptr = g;
         end else m_vld = 0;
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic       rst;
      logic       md;
      logic [1:0] sel;
      logic [3:0] v;
      logic       ordy;
      int         ech;
      logic       evld;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst_n = 0; mode = 1; select = 0; in_valid = '1; out_ready = 1;
      in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

      tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, 0, 1'b0});
      for (int i = 0; i < 5; i++)
         tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, i % 4, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 1, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 3, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 1, 1'b1});
      tbl.push_back('{1'b1, 1'b1, 2'd0, 4'b1010, 1'b1, 3, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd2, 4'b1111, 1'b1, 2, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd2, 4'b1111, 1'b1, 2, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd2, 4'b0000, 1'b1, 2, 1'b0});

      @(negedge clk);
      foreach (tbl[i]) begin
         rst_n = tbl[i].rst; mode = tbl[i].md; select = tbl[i].sel;
         in_valid = tbl[i].v; out_ready = tbl[i].ordy;
         if (!rst_n) begin
            #1;
            chk("rst_in_ready", in_ready, '0);
            #1;
            cyc();
            chk("rst_m_out", m_out, exp_mout());
         end else begin
            if (mode == 1'b0 && in_valid == 4'b1111) begin
               #1 chk("fixed_in_ready", in_ready, 4'b0100);
            end
            cyc();
            if (tbl[i].md == 1'b0 && tbl[i].evld) chk("fixed_m_out", m_out, 8'hA2);
         end
         chk("tbl_out_valid", out_valid, tbl[i].evld);
         if (tbl[i].evld) chk("tbl_out_ch", out_ch, tbl[i].ech[SW-1:0]);
      end

      // Backpressure: load 8'h55 from channel 0, then stall for three cycles.
      mode = 0; select = 0; in_valid = 4'b0001; out_ready = 1;
      in_data = {8'h13, 8'h12, 8'h11, 8'h55};
      cyc();
      chk("bp_load", m_out, 8'h55);
      out_ready = 0; in_valid = 4'b1111; in_data = {8'h23, 8'h22, 8'h21, 8'h20};
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_in_ready", in_ready, '0);
         cyc();
         chk("bp_hold", m_out, 8'h55);
         chk("bp_valid", out_valid, 1'b1);
      end
      out_ready = 1; select = 1;
      #1 chk("bp_release_ready", in_ready, 4'b0010);
      cyc();
      chk("bp_next_word", m_out, 8'h21);
      chk("bp_still_valid", out_valid, 1'b1);

      // Reset while a word is held under backpressure; RR restarts at channel 0.
      out_ready = 0;
      cyc();
      rst_n = 0;
      cyc();
      chk("midrst_valid", out_valid, 1'b0);
      rst_n = 1; mode = 1; out_ready = 1; in_valid = 4'b1111;
      cyc();
      chk("midrst_rr0", out_ch, 2'd0);

      // Out-of-range select on the three-channel instance.
      mode = 0; select = 0; in_valid = 4'b0111; out_ready = 1;
      cyc();
      chk("oor_prime", out_valid3, 1'b1);
      select = 3;
      #1 chk("oor_in_ready", in_ready3, 3'b000);
      cyc();
      chk("oor_valid_fall", out_valid3, 1'b0);

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(0, 39) != 0);
         mode      = 1'($urandom_range(0, 1));
         select    = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = 32'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
